// File: rtl/seven_segment_arbiter.sv
// Round-robin arbiter that time-shares one seven-segment display between requesters,
// holding each grant for a minimum dwell so the shown value is readable.
module seven_segment_arbiter #(
    parameter int unsigned n_req       = 3,
    parameter int unsigned w_digit     = 2,
    parameter int unsigned hold_cycles = 25_000_000,
    parameter logic [w_digit*4-1:0] idle_number = '0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [n_req-1:0]                            req,
    input  logic [n_req*w_digit*4-1:0]                  req_number,
    input  logic [n_req*w_digit-1:0]                    req_dots,
    output logic [n_req-1:0]                            gnt,
    output logic [((n_req > 2) ? $clog2(n_req) : 1)-1:0] owner,
    output logic                                        busy,
    output logic [w_digit*4-1:0]                        number,
    output logic [w_digit-1:0]                          dots
);
    localparam int unsigned W_NUM  = w_digit * 4;
    localparam int unsigned W_OWN  = (n_req > 2) ? $clog2(n_req) : 1;
    localparam int unsigned W_HCNT = $clog2(hold_cycles);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]        r_state;
    logic [W_HCNT-1:0] r_hcnt;
    logic [W_OWN-1:0]  r_last;
    logic [n_req-1:0]  r_gnt;
    logic [W_OWN-1:0]  r_owner;
    logic              r_busy;
    logic [W_NUM-1:0]  r_number;
    logic [w_digit-1:0] r_dots;

    logic [0:0]        w_state_nxt;
    logic [W_HCNT-1:0] w_hcnt_nxt;
    logic [W_OWN-1:0]  w_last_nxt;
    logic [n_req-1:0]  w_gnt_nxt;
    logic [W_OWN-1:0]  w_owner_nxt;
    logic [W_NUM-1:0]  w_number_nxt;
    logic [w_digit-1:0] w_dots_nxt;

    logic [W_OWN-1:0]  w_pick;
    logic              w_pick_vld;
    logic              w_expired;
    logic              w_own_req;
    logic              w_other_req;

    logic [W_NUM-1:0]   w_num_arr [n_req];
    logic [w_digit-1:0] w_dot_arr [n_req];

    for (genvar i = 0; i < n_req; i++) begin : g_slice
        assign w_num_arr[i] = req_number[i*W_NUM +: W_NUM];
        assign w_dot_arr[i] = req_dots[i*w_digit +: w_digit];
    end

    assign w_expired   = (r_hcnt == W_HCNT'(hold_cycles - 1));
    assign w_own_req   = req[r_owner];
    assign w_other_req = |(req & ~r_gnt);

    // First requester after the last owner, wrapping; the last owner itself is checked last.
    always_comb begin : rr_pick
        logic [W_OWN-1:0] idx;
        idx        = '0;
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int unsigned k = 1; k <= n_req; k++) begin
            idx = W_OWN'((32'(r_last) + k) % n_req);
            if (!w_pick_vld && req[idx]) begin
                w_pick     = idx;
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hcnt_nxt   = r_hcnt;
        w_last_nxt   = r_last;
        w_gnt_nxt    = r_gnt;
        w_owner_nxt  = r_owner;
        w_number_nxt = r_number;
        w_dots_nxt   = r_dots;

        case (r_state)
            S_HOLD: begin
                if (!w_expired) begin
                    w_hcnt_nxt = r_hcnt + W_HCNT'(1);
                    if (w_own_req) begin
                        w_number_nxt = w_num_arr[r_owner];
                        w_dots_nxt   = w_dot_arr[r_owner];
                    end
                end else if (w_other_req) begin
                    w_hcnt_nxt   = '0;
                    w_last_nxt   = w_pick;
                    w_gnt_nxt    = n_req'(1) << w_pick;
                    w_owner_nxt  = w_pick;
                    w_number_nxt = w_num_arr[w_pick];
                    w_dots_nxt   = w_dot_arr[w_pick];
                end else if (w_own_req) begin
                    w_number_nxt = w_num_arr[r_owner];
                    w_dots_nxt   = w_dot_arr[r_owner];
                end else begin
                    w_state_nxt  = S_IDLE;
                    w_gnt_nxt    = '0;
                    w_owner_nxt  = '0;
                    w_number_nxt = idle_number;
                    w_dots_nxt   = '0;
                end
            end
            default: begin
                if (w_pick_vld) begin
                    w_state_nxt  = S_HOLD;
                    w_hcnt_nxt   = '0;
                    w_last_nxt   = w_pick;
                    w_gnt_nxt    = n_req'(1) << w_pick;
                    w_owner_nxt  = w_pick;
                    w_number_nxt = w_num_arr[w_pick];
                    w_dots_nxt   = w_dot_arr[w_pick];
                end else begin
                    w_gnt_nxt    = '0;
                    w_owner_nxt  = '0;
                    w_number_nxt = idle_number;
                    w_dots_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_hcnt   <= '0;
            r_last   <= W_OWN'(n_req - 1);
            r_gnt    <= '0;
            r_owner  <= '0;
            r_busy   <= 1'b0;
            r_number <= idle_number;
            r_dots   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_last   <= w_last_nxt;
            r_gnt    <= w_gnt_nxt;
            r_owner  <= w_owner_nxt;
            r_busy   <= |w_gnt_nxt;
            r_number <= w_number_nxt;
            r_dots   <= w_dots_nxt;
        end
    end

    assign gnt    = r_gnt;
    assign owner  = r_owner;
    assign busy   = r_busy;
    assign number = r_number;
    assign dots   = r_dots;

endmodule

// File: doc/seven_segment_arbiter.md
# seven_segment_arbiter

Time-shares one multi-digit seven-segment display between `n_req` requesters, such as a debug counter, a FIFO status view and an error code. It grants the display round-robin and holds each grant for a minimum dwell time so a human can read it. It drives the `number`/`dots` inputs of the existing `seven_segment_display` driver, which handles multiplexing and refresh downstream.

## Interface
- `n_req`, 3, number of requesters (2..8)
- `w_digit`, 2, display digits, matching the downstream display driver
- `hold_cycles`, 25_000_000, minimum grant dwell in clk cycles (≥2; 0.5 s at 50 MHz)
- `idle_number`, 0, `w_digit*4`-bit value shown when nobody holds the display
- `clk` input 1, clock
- `rst` input 1, reset, synchronous, active-high
- `req` input `n_req`, request per requester; level, held while the requester wants the display
- `req_number` input `n_req*w_digit*4`, hex digits per requester; slice i is `[i*w_digit*4 +: w_digit*4]`
- `req_dots` input `n_req*w_digit`, dot bits per requester; slice i is `[i*w_digit +: w_digit]`
- `gnt` output `n_req`, one-hot grant, registered
- `owner` output `$clog2(n_req)` (min 1), index of the granted requester; 0 when idle
- `busy` output 1, high while any grant is active
- `number` output `w_digit*4`, value to the display driver, registered
- `dots` output `w_digit`, dots to the display driver, registered

## Operation
- Two states: IDLE and HOLD. A hold counter `hcnt` counts 0..`hold_cycles-1` and saturates there. `expired` = (`hcnt == hold_cycles-1`).
- Pointer `last` holds the index of the most recent owner. Reset value is `n_req-1`, so the first grant goes to requester 0.
- Round-robin pick: the first requester with `req` high, searching `last+1`, `last+2`, … with wrap modulo `n_req`. The current owner is considered last.
- IDLE, any `req` high:
  - Go to HOLD with the picked requester.
  - Clear `hcnt`, set `last` to the pick.
  - Set `gnt` to the one-hot of the pick.
- IDLE, no request: stay in IDLE with `gnt`=0, `busy`=0, `number`=`idle_number`, `dots`=0.
- HOLD, not `expired`:
  - The grant is unconditional and `hcnt` increments.
  - While the owner's `req` is high, `number`/`dots` follow its slice every cycle, with 1-cycle register latency.
  - If the owner drops `req`, `number`/`dots` freeze at the last value captured while `req` was high. The dwell is always completed.
- HOLD, `expired`, each cycle:
  - Another requester high: switch directly to the round-robin pick (from `last`). Clear `hcnt`, update `last`. There is no idle gap.
  - Only the owner is requesting: keep the grant; `hcnt` stays saturated.
  - Nobody is requesting: go to IDLE.
- Requests from non-owners never affect the display or `gnt` before `expired`.
- `owner` always equals the index of the set bit in `gnt`. `busy` = |`gnt`.

## Timing
- Reset (synchronous, any state, including mid-hold) sets:
  - state IDLE, `gnt`=0, `owner`=0, `busy`=0
  - `number`=`idle_number`, `dots`=0
  - `hcnt`=0, `last`=`n_req-1`
- Grant latency: `req` high in cycle t while IDLE gives `gnt`/`busy` high and `number` = that requester's slice in cycle t+1.
- Data latency while the owner's `req` is high: `req_number` in cycle t appears on `number` in cycle t+1.
- Minimum dwell: a grant asserted at cycle t stays until at least t+`hold_cycles`. The earliest handoff is visible at cycle t+`hold_cycles`.
- On handoff, `gnt`, `owner`, `number` and `dots` change in the same cycle; `gnt` is never two-hot and never zero between owners.
- Release: owner not requesting and no others at the `expired` cycle gives `gnt`=0 and `number`=`idle_number` on the next cycle.
- Simultaneous requests in IDLE: the lowest index after `last` (with wrap) wins.

## Test plan
- Reset/idle:
  - Stimulus: assert `rst` mid-HOLD with `n_req`=3, `hold_cycles`=4.
  - Response: next cycle `gnt`=0, `busy`=0, `number`=`idle_number`. A subsequent `req`=3'b111 grants requester 0.
- Single requester:
  - Stimulus: `req`=3'b010 with `req_number`[1] = 8'h5A, then change it to 8'hC3.
  - Response: `gnt`=3'b010 one cycle later, `number`=8'h5A, then 8'hC3 one cycle after the change. The grant holds indefinitely while `req` stays high.
- Minimum dwell with early drop:
  - Stimulus: requester 2 granted with 8'h77, drops `req` after 1 cycle, and requester 0 requests.
  - Response: `number` stays 8'h77 and `gnt`=3'b100 for exactly 4 cycles from grant, then `gnt`=3'b001 with no idle cycle.
- Round-robin fairness:
  - Stimulus: `req`=3'b111 held constant.
  - Response: grants cycle 0→1→2→0, each exactly `hold_cycles` long. `owner` tracks `gnt`.
- Release to idle:
  - Stimulus: the owner drops `req` after `expired` with no other requests.
  - Response: next cycle `gnt`=0 and `number`=`idle_number`. A new `req`=3'b001 then grants after 1 cycle.
- Late contender:
  - Stimulus: requester 1 asserts `req` during requester 0's dwell and requester 0 keeps requesting.
  - Response: the switch to requester 1 happens exactly at dwell end and not earlier.
